// File: rtl/tdc_pkg.sv
// Shared constants, detector state encoding and width helper for the TDC readout path.
package tdc_pkg;

  localparam int G_LEN      = 32;
  localparam int G_AVG_LOG2 = 4;
  localparam int G_HOLDOFF  = 16;

  typedef enum logic [1:0] {
    DET_IDLE    = 2'd0,
    DET_ARMED   = 2'd1,
    DET_DETECT  = 2'd2,
    DET_HOLDOFF = 2'd3
  } det_state_e;

  // Width needed to hold a tap count of 0..len.
  function automatic int tdc_vw(input int len);
    return $clog2(len + 1);
  endfunction

endpackage

// File: rtl/tdc_popcount.sv
// Bubble correction (3-tap majority) followed by a population count of the corrected code.
module tdc_popcount
  import tdc_pkg::*;
#(
  parameter  int g_LEN = G_LEN,
  localparam int VW    = tdc_vw(g_LEN)
) (
  input  logic [g_LEN-1:0] r,
  output logic [VW-1:0]    count
);

  // Tap -1 reads as 1 and tap g_LEN as 0, so edges of the line vote like a full code.
  logic [g_LEN+1:0] ext;
  logic [g_LEN-1:0] c;

  assign ext = {1'b0, r, 1'b1};

  always_comb begin
    c     = '0;
    count = '0;
    for (int i = 0; i < g_LEN; i++) begin
      c[i] = (ext[i] & ext[i+1]) | (ext[i] & ext[i+2]) | (ext[i+1] & ext[i+2]);
    end
    for (int i = 0; i < g_LEN; i++) begin
      count = count + VW'(c[i]);
    end
  end

endmodule

// File: rtl/tdc_readout.sv
// TDC sample readout: 3-stage thermometer-to-binary pipeline, windowed statistics
// and an armed droop detector with holdoff.
module tdc_readout
  import tdc_pkg::*;
#(
  parameter  int g_LEN      = G_LEN,
  parameter  int g_AVG_LOG2 = G_AVG_LOG2,
  parameter  int g_HOLDOFF  = G_HOLDOFF,
  localparam int VW         = tdc_vw(g_LEN)
) (
  input  logic             clkSample,
  input  logic             rst_n,
  input  logic [g_LEN-1:0] raw,
  input  logic             arm,
  input  logic [VW-1:0]    threshold,
  output logic [VW-1:0]    value,
  output logic             value_valid,
  output logic [VW-1:0]    avg,
  output logic [VW-1:0]    min_val,
  output logic [VW-1:0]    max_val,
  output logic             win_done,
  output logic             drop_det,
  output logic [1:0]       det_state
);

  localparam int AW = VW + g_AVG_LOG2;
  localparam int HW = (g_HOLDOFF > 1) ? $clog2(g_HOLDOFF) : 1;
  localparam logic [g_AVG_LOG2-1:0] WIN_LAST  = '1;
  localparam logic [VW-1:0]         VAL_MAX   = VW'(g_LEN);
  localparam logic [HW-1:0]         HOLD_LOAD = HW'(g_HOLDOFF - 1);

  // ---------------- conversion pipeline ----------------
  logic [g_LEN-1:0] raw_s1, raw_s2;
  logic             vld_s1, vld_s2;
  logic [VW-1:0]    pop_count;

  always_ff @(posedge clkSample or negedge rst_n) begin
    if (!rst_n) begin
      raw_s1      <= '0;
      raw_s2      <= '0;
      vld_s1      <= 1'b0;
      vld_s2      <= 1'b0;
      value       <= '0;
      value_valid <= 1'b0;
    end else begin
      raw_s1      <= raw;
      raw_s2      <= raw_s1;
      vld_s1      <= 1'b1;
      vld_s2      <= vld_s1;
      value       <= pop_count;
      value_valid <= vld_s2;
    end
  end

  tdc_popcount #(.g_LEN(g_LEN)) u_popcount (
    .r     (raw_s2),
    .count (pop_count)
  );

  // ---------------- window statistics ----------------
  logic [AW-1:0]         sum, sum_next;
  logic [VW-1:0]         run_min, run_max, min_next, max_next;
  logic [g_AVG_LOG2-1:0] win_cnt;

  always_comb begin
    sum_next = sum + AW'(value);
    min_next = (value < run_min) ? value : run_min;
    max_next = (value > run_max) ? value : run_max;
  end

  always_ff @(posedge clkSample or negedge rst_n) begin
    if (!rst_n) begin
      sum      <= '0;
      run_min  <= VAL_MAX;
      run_max  <= '0;
      win_cnt  <= '0;
      avg      <= '0;
      min_val  <= '0;
      max_val  <= '0;
      win_done <= 1'b0;
    end else begin
      win_done <= 1'b0;
      if (value_valid) begin
        if (win_cnt == WIN_LAST) begin
          // Closing sample is folded into the published results, then the window restarts.
          avg      <= VW'(sum_next >> g_AVG_LOG2);
          min_val  <= min_next;
          max_val  <= max_next;
          win_done <= 1'b1;
          sum      <= '0;
          run_min  <= VAL_MAX;
          run_max  <= '0;
          win_cnt  <= '0;
        end else begin
          sum     <= sum_next;
          run_min <= min_next;
          run_max <= max_next;
          win_cnt <= win_cnt + 1'b1;
        end
      end
    end
  end

  // ---------------- droop detector ----------------
  det_state_e    state, state_next;
  logic [HW-1:0] hold_cnt, hold_next;

  always_ff @(posedge clkSample or negedge rst_n) begin
    if (!rst_n) begin
      state    <= DET_IDLE;
      hold_cnt <= '0;
    end else begin
      state    <= state_next;
      hold_cnt <= hold_next;
    end
  end

  always_comb begin
    state_next = state;
    hold_next  = hold_cnt;
    drop_det   = 1'b0;
    case (state)
      DET_IDLE: begin
        if (arm) state_next = DET_ARMED;
      end
      DET_ARMED: begin
        if (!arm) state_next = DET_IDLE;
        else if (value_valid && (value < threshold)) state_next = DET_DETECT;
      end
      DET_DETECT: begin
        drop_det   = 1'b1;
        hold_next  = HOLD_LOAD;
        state_next = DET_HOLDOFF;
      end
      DET_HOLDOFF: begin
        // Holdoff always runs to completion; arm only picks the exit state.
        if (hold_cnt == '0) state_next = arm ? DET_ARMED : DET_IDLE;
        else hold_next = hold_cnt - 1'b1;
      end
      default: state_next = DET_IDLE;
    endcase
  end

  assign det_state = state;

endmodule

// File: tb/tb_tdc_readout.sv
// Directed bench for tdc_readout: conversion, window statistics, detector and mid-run reset.
module tb_tdc_readout;

  logic        clkSample = 1'b0;
  logic        rst_n     = 1'b0;
  logic [31:0] raw       = '0;
  logic        arm       = 1'b0;
  logic [5:0]  threshold = '0;
  logic [5:0]  value, avg, min_val, max_val;
  logic        value_valid, win_done, drop_det;
  logic [1:0]  det_state;

  int total = 0;
  int bad   = 0;

  always #5 clkSample = ~clkSample;

  tdc_readout dut (
    .clkSample   (clkSample),
    .rst_n       (rst_n),
    .raw         (raw),
    .arm         (arm),
    .threshold   (threshold),
    .value       (value),
    .value_valid (value_valid),
    .avg         (avg),
    .min_val     (min_val),
    .max_val     (max_val),
    .win_done    (win_done),
    .drop_det    (drop_det),
    .det_state   (det_state)
  );

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clkSample);
    #1;
  endtask

  // Leaves the bench 1 time unit after an edge with reset released; the next edge is edge 1.
  task automatic reset_dut(input logic [31:0] r0, input logic a, input logic [5:0] th);
    rst_n     = 1'b0;
    raw       = r0;
    arm       = a;
    threshold = th;
    step();
    rst_n = 1'b1;
  endtask

  function automatic logic [31:0] therm(input int n);
    logic [31:0] ones;
    ones = 32'hFFFF_FFFF;
    if (n <= 0) return 32'h0;
    return ones >> (32 - n);
  endfunction

  // ---------------- tests ----------------
  task automatic test_reset();
    int pulses;
    rst_n = 1'b0; raw = 32'h0000FFFF; arm = 1'b0; threshold = '0;
    step(); step();
    total++;
    if ({value, value_valid, avg, min_val, max_val, win_done, drop_det, det_state} !== 29'd0) begin
      bad++;
      $display("FAIL reset_outputs: got value=%0d valid=%0d avg=%0d min=%0d max=%0d wd=%0d dd=%0d st=%0d required all 0",
               value, value_valid, avg, min_val, max_val, win_done, drop_det, det_state);
    end
    rst_n  = 1'b1;
    pulses = 0;
    for (int e = 1; e <= 20; e++) begin
      step();
      if (e == 2) begin
        total++;
        if (value_valid !== 1'b0) begin bad++; $display("FAIL valid_early: got %0d required 0", value_valid); end
      end else if (e == 3) begin
        total++;
        if (value_valid !== 1'b1) begin bad++; $display("FAIL valid_edge3: got %0d required 1", value_valid); end
        total++;
        if (value !== 6'd16) begin bad++; $display("FAIL value_edge3: got %0d required 16", value); end
      end else if (e == 19) begin
        total++;
        if (win_done !== 1'b1) begin bad++; $display("FAIL const_win_done: got %0d required 1", win_done); end
        total++;
        if ({avg, min_val, max_val} !== {6'd16, 6'd16, 6'd16}) begin
          bad++;
          $display("FAIL const_stats: got avg=%0d min=%0d max=%0d required 16/16/16", avg, min_val, max_val);
        end
      end else if (win_done === 1'b1) begin
        pulses++;
      end
    end
    total++;
    if (pulses !== 0) begin bad++; $display("FAIL const_extra_win_done: got %0d required 0", pulses); end
  endtask

  task automatic test_extremes();
    raw = 32'hFFFF_FFFF; step(); step(); step();
    total++;
    if (value !== 6'd32) begin bad++; $display("FAIL all_ones: got %0d required 32", value); end
    raw = 32'h0; step(); step(); step();
    total++;
    if (value !== 6'd0) begin bad++; $display("FAIL all_zeros: got %0d required 0", value); end
  endtask

  task automatic test_bubble();
    logic [31:0] vec [4];
    logic [5:0]  exp [4];
    vec[0] = 32'h0000FF7F; exp[0] = 6'd16;
    vec[1] = 32'h00010FFF; exp[1] = 6'd12;
    vec[2] = 32'h00000002; exp[2] = 6'd1;
    vec[3] = 32'h80000000; exp[3] = 6'd0;
    for (int i = 0; i < 4; i++) begin
      raw = vec[i]; step(); step(); step();
      total++;
      if (value !== exp[i]) begin
        bad++;
        $display("FAIL bubble_%0d: raw=%h got %0d required %0d", i, vec[i], value, exp[i]);
      end
    end
  endtask

  task automatic test_window();
    int pulses = 0;
    reset_dut(therm(1), 1'b0, 6'd0);
    for (int e = 1; e <= 36; e++) begin
      if (e <= 16)      raw = therm(e);
      else if (e == 24) raw = therm(14);
      else if (e <= 32) raw = therm(12);
      else              raw = 32'h0;
      step();
      if (e == 19) begin
        total++;
        if (win_done !== 1'b1) begin bad++; $display("FAIL ramp_win_done: got %0d required 1", win_done); end
        total++;
        if ({avg, min_val, max_val} !== {6'd8, 6'd1, 6'd16}) begin
          bad++;
          $display("FAIL ramp_stats: got avg=%0d min=%0d max=%0d required 8/1/16", avg, min_val, max_val);
        end
      end else if (e == 35) begin
        total++;
        if (win_done !== 1'b1) begin bad++; $display("FAIL win2_win_done: got %0d required 1", win_done); end
        total++;
        if ({avg, min_val, max_val} !== {6'd12, 6'd12, 6'd14}) begin
          bad++;
          $display("FAIL win2_stats: got avg=%0d min=%0d max=%0d required 12/12/14", avg, min_val, max_val);
        end
      end else if (win_done === 1'b1) begin
        pulses++;
      end
    end
    total++;
    if (pulses !== 0) begin bad++; $display("FAIL window_extra_win_done: got %0d required 0", pulses); end
  endtask

  task automatic test_detector();
    logic [1:0] exp_st;
    reset_dut(therm(12), 1'b1, 6'd10);
    for (int e = 1; e <= 30; e++) begin
      if (e == 2 || e == 25)     raw = therm(10);
      else if (e >= 4 && e <= 6) raw = therm(9);
      else                       raw = therm(12);
      if (e == 10) arm = 1'b0;
      if (e == 22) arm = 1'b1;
      step();
      if (e == 7)                 exp_st = 2'd2;
      else if (e >= 8 && e <= 23) exp_st = 2'd3;
      else                        exp_st = 2'd1;
      total++;
      if (det_state !== exp_st) begin
        bad++;
        $display("FAIL det_state_e%0d: got %0d required %0d", e, det_state, exp_st);
      end
      total++;
      if (drop_det !== (e == 7)) begin
        bad++;
        $display("FAIL drop_det_e%0d: got %0d required %0d", e, drop_det, (e == 7));
      end
    end
  endtask

  task automatic test_thresholds();
    int pulses = 0;
    reset_dut(32'h0, 1'b1, 6'd0);
    for (int e = 1; e <= 10; e++) begin
      step();
      if (drop_det === 1'b1) pulses++;
    end
    total++;
    if (pulses !== 0) begin bad++; $display("FAIL thr0_pulses: got %0d required 0", pulses); end
    total++;
    if (det_state !== 2'd1) begin bad++; $display("FAIL thr0_state: got %0d required 1", det_state); end
    threshold = 6'd33;
    raw       = 32'hFFFF_FFFF;
    pulses    = 0;
    for (int e = 1; e <= 8; e++) begin
      step();
      if (drop_det === 1'b1) pulses++;
    end
    total++;
    if (pulses !== 1) begin bad++; $display("FAIL thr33_pulses: got %0d required 1", pulses); end
    total++;
    if (det_state !== 2'd3) begin bad++; $display("FAIL thr33_state: got %0d required 3", det_state); end
  endtask

  task automatic test_mid_reset();
    int pulses = 0;
    int drops  = 0;
    reset_dut(therm(12), 1'b1, 6'd13);
    for (int e = 1; e <= 10; e++) step();
    total++;
    if (det_state !== 2'd3) begin bad++; $display("FAIL pre_reset_state: got %0d required 3", det_state); end
    rst_n = 1'b0;
    #1;
    total++;
    if ({value, value_valid, win_done, drop_det, det_state} !== 11'd0) begin
      bad++;
      $display("FAIL mid_reset_outputs: got value=%0d valid=%0d wd=%0d dd=%0d st=%0d required all 0",
               value, value_valid, win_done, drop_det, det_state);
    end
    arm = 1'b0; threshold = 6'd0; raw = therm(12);
    step();
    rst_n = 1'b1;
    for (int e = 1; e <= 20; e++) begin
      step();
      if (drop_det === 1'b1) drops++;
      if (e == 19) begin
        total++;
        if (win_done !== 1'b1) begin bad++; $display("FAIL post_reset_win_done: got %0d required 1", win_done); end
        total++;
        if ({avg, min_val, max_val} !== {6'd12, 6'd12, 6'd12}) begin
          bad++;
          $display("FAIL post_reset_stats: got avg=%0d min=%0d max=%0d required 12/12/12", avg, min_val, max_val);
        end
      end else if (win_done === 1'b1) begin
        pulses++;
      end
    end
    total++;
    if (pulses !== 0) begin bad++; $display("FAIL post_reset_spurious_win: got %0d required 0", pulses); end
    total++;
    if (drops !== 0) begin bad++; $display("FAIL post_reset_spurious_drop: got %0d required 0", drops); end
  endtask

  initial begin
    test_reset();
    test_extremes();
    test_bubble();
    test_window();
    test_detector();
    test_thresholds();
    test_mid_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
